// File: rtl/brew_scheduler.sv
// Round-robin scheduler sharing one coffee machine between NUM_REQ requesters.
// Latches requests, grants the machine, and sequences ready/brew/stop per order.
module brew_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int BREW_CYCLES = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               mach_ready,
    input  logic               mach_brewing,
    output logic               B,
    output logic               S,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] pending,
    output logic               busy
);
    localparam int CNT_W = $clog2(BREW_CYCLES + 1);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BREW_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_REQ - 1);
    localparam logic [IDX_W:0]   NUM_L    = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W:0]   ONE_L    = (IDX_W + 1)'(1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_READY = 3'd1,
        START      = 3'd2,
        BREWING    = 3'd3,
        STOP       = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   gidx;
    logic [NUM_REQ-1:0] pend_eff;
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W:0]     last_p1;
    logic [IDX_W:0]     pick_ofs;
    logic [IDX_W:0]     pick_sum;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_vld;

    // Requests arriving this cycle are eligible immediately, so an idle
    // scheduler grants on the same edge that latches the request.
    assign pend_eff = pending | req;

    // Rotate so that bit 0 is the requester after 'last'; the lowest set bit wins.
    always_comb begin
        last_p1  = {1'b0, last} + ONE_L;
        rot      = NUM_REQ'({pend_eff, pend_eff} >> last_p1);
        pick_vld = 1'b0;
        pick_ofs = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pick_vld = 1'b1;
                pick_ofs = (IDX_W + 1)'(j);
            end
        end
        pick_sum = last_p1 + pick_ofs;
        pick_idx = (pick_sum >= NUM_L) ? IDX_W'(pick_sum - NUM_L) : IDX_W'(pick_sum);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            grant   <= '0;
            done    <= '0;
            B       <= 1'b0;
            S       <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
            last    <= IDX_MAX;
            gidx    <= '0;
        end else begin
            pending <= ((state == DONE) ? (pending & ~grant) : pending) | req;
            done    <= '0;
            B       <= 1'b0;
            S       <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state <= WAIT_READY;
                        grant <= NUM_REQ'(1) << pick_idx;
                        gidx  <= pick_idx;
                        busy  <= 1'b1;
                    end
                end
                WAIT_READY: begin
                    if (mach_ready) begin
                        state <= START;
                        B     <= 1'b1;
                    end
                end
                START: begin
                    if (mach_brewing) begin
                        state <= BREWING;
                        cnt   <= '0;
                    end else begin
                        B <= 1'b1;
                    end
                end
                // The counter holds at its exit value rather than wrapping.
                BREWING: begin
                    if (cnt == CNT_LAST) begin
                        state <= STOP;
                        S     <= 1'b1;
                    end else if (!mach_brewing) begin
                        state <= DONE;
                        done  <= grant;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (!mach_brewing) begin
                        state <= DONE;
                        done  <= grant;
                    end else begin
                        S <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    last  <= gidx;
                    grant <= '0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/brew_scheduler.md
# brew_scheduler

Shares one coffee-machine FSM between `NUM_REQ` requesters. Latches brew requests, grants the machine round-robin, and sequences it for each order. The sequence is: wait for the machine's ready output, pulse Brew, time the brew for a fixed duration, assert Stop, and report completion. It sits between the user request inputs and the machine's `B`/`S` inputs, observing the machine's `G` (ready) and `Brew` outputs.

## Interface
- `NUM_REQ`, default 4: number of requesters, minimum 2.
- `BREW_CYCLES`, default 16: number of clock cycles the machine stays brewing per order, minimum 1.
- `clock`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req`  input  `NUM_REQ`  one-cycle or level request per requester; sampled every cycle.
- `mach_ready`  input  1  machine `G` output (ready to brew).
- `mach_brewing`  input  1  machine `Brew` output.
- `B`  output  1  brew command to machine.
- `S`  output  1  stop command to machine.
- `grant`  output  `NUM_REQ`  one-hot requester currently being served; 0 when idle.
- `done`  output  `NUM_REQ`  one-cycle one-hot completion pulse.
- `pending`  output  `NUM_REQ`  latched outstanding requests.
- `busy`  output  1  high in every state except IDLE.

## Operation
- Pending register:
  - Bit i is set on any cycle with `req[i]`=1.
  - Bit i is cleared in the DONE cycle for requester i, unless `req[i]`=1 in that same cycle; set wins.
  - A repeat request while already pending has no additional effect. There is no queue depth beyond one order per requester.
- Arbitration (evaluated only in IDLE):
  - Search starts at index `last+1` and wraps modulo `NUM_REQ`. The first pending bit found is granted.
  - `last` is updated to the served index in DONE. Reset value of `last` is `NUM_REQ-1`, so requester 0 has first priority.
- States and transitions:
  - IDLE: if `pending`≠0, latch grant and go to WAIT_READY; else stay.
  - WAIT_READY: stay until `mach_ready`=1, then go to START.
  - START: `B`=1; stay until `mach_brewing`=1, then go to BREWING with the counter cleared to 0.
  - BREWING:
    - The counter increments each cycle.
    - When the counter reaches `BREW_CYCLES-1`, go to STOP.
    - If `mach_brewing` drops early, go directly to DONE; the order counts as complete.
  - STOP: `S`=1; stay until `mach_brewing`=0, then go to DONE.
  - DONE: `done[grant]`=1 for one cycle; clear pending per the rule above; update `last`; go to IDLE.
  - Unused encodings go to IDLE.
- Outputs `B`, `S`, `grant`, `done` and `busy` are Moore decodes of the state, grant and counter registers. There is no combinational path from any input to any output.
- `grant` is held constant from WAIT_READY through DONE inclusive. Requests arriving during service only update `pending`.
- Counter width is `$clog2(BREW_CYCLES+1)`. The counter never wraps: it saturates at the exit value.
- `B` and `S` are never both 1 in the same cycle.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE; `pending`, `grant`, `done`, `B`, `S`, `busy` and the counter = 0; `last` = `NUM_REQ-1`.
  - Reset mid-order drops the order with no `done` pulse and releases `B`/`S` immediately.
- `req` sampled at edge k sets `pending` visible at cycle k+1. If idle, the IDLE→WAIT_READY transition occurs on the same edge, so `grant` is visible at k+1.
- The minimum order length from grant to `done` is 1 (WAIT_READY) + 1 (START) + `BREW_CYCLES` + 1 (STOP) + 1 (DONE) cycles. This holds when the machine responds within one cycle.
- `B` stays high as long as `mach_brewing` is low in START. It drops on the edge after `mach_brewing` is sampled high.
- `S` behaves the same way in STOP, dropping on the edge after `mach_brewing` is sampled low.
- `done` is high for exactly one cycle, and `grant` is still valid in that cycle. The next arbitration happens in the cycle after DONE, because IDLE lasts at least one cycle between orders.

## Test plan
All scenarios use `NUM_REQ`=4 and `BREW_CYCLES`=4, with a model machine that responds in one cycle.
- Reset then single order: `req`=0001 for one cycle.
  - `grant`=0001 next cycle.
  - `B` high 1–2 cycles, then `mach_brewing` high for 4 counted cycles.
  - `S` asserted until `mach_brewing` falls, then `done`=0001 for one cycle and `pending`=0000.
- Round-robin: `req`=1111 in one cycle.
  - Grants are served in order 0001, 0010, 0100, 1000.
  - Four `done` pulses occur in the same order, and `pending` decrements bitwise.
- Fairness wrap: after serving requester 2, assert `req`=0101 → next grant is 0001 (search wraps from 3), not 0100.
- Early machine drop:
  - Force `mach_brewing` low 2 cycles into BREWING → DONE with no `S` assertion.
  - `done` pulses and the state returns to IDLE.
- Simultaneous events:
  - `req[1]` high in the DONE cycle of requester 1 → `pending[1]` stays 1, and requester 1 is re-served after the other pending requesters.
  - Holding `mach_ready`=0 keeps the state in WAIT_READY with `B`=0 indefinitely.
- Reset mid-brew: assert `reset` during BREWING → same cycle `B`=`S`=0, `grant`=0, `pending`=0, `busy`=0, and no `done` pulse occurs.
